// File: rtl/hiscore_upload_reader.sv
// Serves HPS upload byte reads from a window of game RAM through a shared,
// arbitrated RAM port, tracks window dirtiness and raises save requests.
module hiscore_upload_reader #(
  parameter int                RAM_AW       = 16,
  parameter logic [RAM_AW-1:0] BASE         = 16'h5000,
  parameter int                REGION_LEN   = 256,
  parameter logic [7:0]        UPLOAD_INDEX = 8'd4
) (
  input  logic              clk_49m,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_wr_mon,
  input  logic              save_trigger,
  output logic              upload_req,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, CAPTURE} state_t;

  localparam logic [24:0] REGION_LEN_W = 25'(REGION_LEN);
  localparam logic [24:0] LAST_OFF_W   = 25'(REGION_LEN - 1);

  state_t            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              req_q, req_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              pend_vld_q, pend_vld_d;
  logic [24:0]       pend_addr_q, pend_addr_d;
  logic              cur_last_q, cur_last_d;
  logic              got_last_q, got_last_d;
  logic              dirty_q, dirty_d;
  logic              upload_prev_q, upload_prev_d;
  logic              save_prev_q, save_prev_d;
  logic              upreq_q, upreq_d;

  logic              accept;
  logic [24:0]       launch_addr;

  assign accept = ioctl_rd & ioctl_upload & (ioctl_index == UPLOAD_INDEX);

  always_comb begin
    state_d       = state_q;
    din_d         = din_q;
    req_d         = req_q;
    addr_d        = addr_q;
    busy_d        = busy_q;
    pend_vld_d    = pend_vld_q;
    pend_addr_d   = pend_addr_q;
    cur_last_d    = cur_last_q;
    got_last_d    = got_last_q;
    dirty_d       = dirty_q;
    upload_prev_d = ioctl_upload;
    save_prev_d   = save_trigger;
    upreq_d       = 1'b0;
    launch_addr   = accept ? ioctl_addr : pend_addr_q;

    // Reads arriving while a transaction is in flight park in the pending slot;
    // the newest one wins.
    if (accept && (state_q != IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = ioctl_addr;
    end

    case (state_q)
      IDLE: begin
        if (accept || pend_vld_q) begin
          pend_vld_d = 1'b0;
          if (launch_addr >= REGION_LEN_W) begin
            din_d = 8'hFF;
          end else begin
            addr_d     = BASE + launch_addr[RAM_AW-1:0];
            req_d      = 1'b1;
            busy_d     = 1'b1;
            cur_last_d = (launch_addr == LAST_OFF_W);
            state_d    = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        // A grant always wins over an abort: the RAM access is already committed.
        if (ram_gnt) begin
          state_d = CAPTURE;
        end else if (!ioctl_upload) begin
          req_d      = 1'b0;
          busy_d     = 1'b0;
          pend_vld_d = 1'b0;
          state_d    = IDLE;
        end
      end
      CAPTURE: begin
        din_d   = ram_rdata;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (ioctl_upload && cur_last_q) begin
          got_last_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A save only counts as complete if the last window byte went out.
    if (upload_prev_q && !ioctl_upload) begin
      got_last_d = 1'b0;
      if (got_last_q) begin
        dirty_d = 1'b0;
      end
    end
    if (ram_wr_mon && !ioctl_upload) begin
      dirty_d = 1'b1;
    end

    upreq_d = save_trigger & ~save_prev_q & dirty_q & ~ioctl_upload;
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      din_q         <= 8'h00;
      req_q         <= 1'b0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_addr_q   <= '0;
      cur_last_q    <= 1'b0;
      got_last_q    <= 1'b0;
      dirty_q       <= 1'b0;
      upload_prev_q <= 1'b0;
      save_prev_q   <= 1'b0;
      upreq_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_q         <= din_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      pend_vld_q    <= pend_vld_d;
      pend_addr_q   <= pend_addr_d;
      cur_last_q    <= cur_last_d;
      got_last_q    <= got_last_d;
      dirty_q       <= dirty_d;
      upload_prev_q <= upload_prev_d;
      save_prev_q   <= save_prev_d;
      upreq_q       <= upreq_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ram_req    = req_q;
  assign ram_addr   = addr_q;
  assign busy       = busy_q;
  assign upload_req = upreq_q;

endmodule

// File: tb/tb_hiscore_upload_reader.sv
// Directed bench for hiscore_upload_reader with a behavioural RAM that answers
// one cycle after each granted request cycle.
module tb_hiscore_upload_reader;

  logic        clk_49m = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ram_req;
  logic        ram_gnt;
  logic [15:0] ram_addr;
  logic [7:0]  ram_rdata = 8'h00;
  logic        ram_wr_mon = 1'b0;
  logic        save_trigger = 1'b0;
  logic        upload_req;
  logic        busy;

  logic        gnt_en = 1'b0;
  logic [7:0]  mem [0:65535];
  int          req_cycles = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  saved_din;
  int          req_snap;

  always #5 clk_49m = ~clk_49m;

  assign ram_gnt = gnt_en;

  always @(posedge clk_49m) begin
    if (ram_req && ram_gnt) ram_rdata <= mem[ram_addr];
    if (ram_req) req_cycles <= req_cycles + 1;
  end

  hiscore_upload_reader dut (
    .clk_49m     (clk_49m),
    .reset       (reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ram_req     (ram_req),
    .ram_gnt     (ram_gnt),
    .ram_addr    (ram_addr),
    .ram_rdata   (ram_rdata),
    .ram_wr_mon  (ram_wr_mon),
    .save_trigger(save_trigger),
    .upload_req  (upload_req),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'h5010] = 8'hA5;

    // reset state
    tick();
    tick();
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_req", ram_req, 0);
    chk("rst_addr", ram_addr, 16'h0000);
    chk("rst_upreq", upload_req, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // basic read, grant always high
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    gnt_en       = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h10;
    tick();
    ioctl_rd = 1'b0;
    chk("t1_req", ram_req, 1);
    chk("t1_addr", ram_addr, 16'h5010);
    chk("t1_busy", busy, 1);
    tick();
    tick();
    chk("t1_din", ioctl_din, 8'hA5);
    chk("t1_busy_after", busy, 0);
    chk("t1_req_after", ram_req, 0);

    // out-of-range read
    tick();
    req_snap = req_cycles;
    ioctl_rd = 1'b1; ioctl_addr = 25'd300;
    tick();
    ioctl_rd = 1'b0;
    chk("t2_din", ioctl_din, 8'hFF);
    chk("t2_req", ram_req, 0);
    tick(); tick(); tick();
    chk("t2_noreq", req_cycles, req_snap);

    // delayed grant with a second read parked in the pending slot
    gnt_en = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h30;
    tick();                                   // N+1
    ioctl_rd = 1'b0;
    chk("t3_req_wait", ram_req, 1);
    tick();                                   // N+2
    ioctl_rd = 1'b1; ioctl_addr = 25'h11;
    tick();                                   // N+3
    ioctl_rd = 1'b0;
    chk("t3_addr_hold", ram_addr, 16'h5030);
    tick();                                   // N+4
    tick();                                   // N+5
    chk("t3_busy_wait", busy, 1);
    tick();                                   // N+6
    gnt_en = 1'b1;
    tick();                                   // N+7
    tick();                                   // N+8
    chk("t3_din1", ioctl_din, mem[16'h5030]);
    chk("t3_req_gap", ram_req, 0);
    tick();                                   // N+9
    chk("t3_req2", ram_req, 1);
    chk("t3_addr2", ram_addr, 16'h5011);
    tick();
    tick();
    chk("t3_din2", ioctl_din, mem[16'h5011]);
    chk("t3_busy_end", busy, 0);

    // abort while waiting for grant, pending read discarded
    saved_din = ioctl_din;
    gnt_en = 1'b0;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h40;
    tick();
    ioctl_addr = 25'h41;
    chk("t4_req", ram_req, 1);
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    chk("t4_req_drop", ram_req, 0);
    chk("t4_busy", busy, 0);
    chk("t4_din", ioctl_din, saved_din);
    ioctl_upload = 1'b1;
    gnt_en = 1'b1;
    req_snap = req_cycles;
    tick(); tick(); tick(); tick();
    chk("t4_pend_clr", req_cycles, req_snap);
    chk("t4_din_keep", ioctl_din, saved_din);

    // clean window: a save edge raises nothing
    ioctl_upload = 1'b0;
    tick();
    save_trigger = 1'b1;
    tick();
    chk("t5_clean_nopulse", upload_req, 0);
    tick();
    chk("t5_clean_nopulse2", upload_req, 0);
    save_trigger = 1'b0;
    tick();

    // dirty window: one-cycle pulse
    ram_wr_mon = 1'b1;
    tick();
    ram_wr_mon = 1'b0;
    save_trigger = 1'b1;
    tick();
    chk("t5_pulse", upload_req, 1);
    tick();
    chk("t5_pulse_end", upload_req, 0);
    save_trigger = 1'b0;
    tick();

    // full upload of the window clears dirty
    ioctl_upload = 1'b1;
    tick();
    for (int a = 0; a < 256; a++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(a);
      tick();
      ioctl_rd = 1'b0;
      tick(); tick();
      chk($sformatf("t5_byte%0d", a), ioctl_din, mem[16'h5000 + 16'(a)]);
      tick();
    end
    ioctl_upload = 1'b0;
    tick(); tick();
    save_trigger = 1'b1;
    tick();
    chk("t5_after_save", upload_req, 0);
    tick();
    chk("t5_after_save2", upload_req, 0);
    save_trigger = 1'b0;
    tick();

    // wrong index is ignored
    ioctl_upload = 1'b1;
    ioctl_index = 8'd0;
    saved_din = ioctl_din;
    req_snap = req_cycles;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'h10;
    tick();
    ioctl_rd = 1'b0;
    tick(); tick(); tick();
    chk("t6_idx_noreq", req_cycles, req_snap);
    chk("t6_idx_din", ioctl_din, saved_din);

    // async reset in WAIT_GNT
    ioctl_index = 8'd4;
    gnt_en = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h20;
    tick();
    ioctl_rd = 1'b0;
    chk("t6_req_pre", ram_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_req", ram_req, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_din", ioctl_din, 8'h00);
    chk("t6_rst_addr", ram_addr, 16'h0000);
    chk("t6_rst_upreq", upload_req, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
